uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received character on the receiver's single-cycle FIFO write-enable pulse.
- Presents characters to the host/bus side with a first-word-fall-through valid/ready interface.
- Tracks occupancy, sticky overflow and frame-error status per character.

Parameters:
- DataLength, 8, character width; must match the receiver.
- Depth, 16, number of entries; must be a power of two, minimum 2.
- AlmostFull, 12, level at or above which o_almost_full asserts; range 1..Depth.

Ports:
- i_clk  input  1  system clock, same clock as the receiver
- i_rst  input  1  asynchronous, active-high reset
- i_wr_en  input  1  write strobe from the receiver's FIFO write-enable output; one-cycle pulse
- i_wr_data  input  DataLength  received character, from the receiver's data output
- i_parity_error  input  1  receiver parity error, sampled with i_wr_en
- i_stop_bit_error  input  1  receiver stop-bit error, sampled with i_wr_en
- o_rd_valid  output  1  head entry available
- i_rd_ready  input  1  consumer accepts the head entry
- o_rd_data  output  DataLength  head character
- o_rd_err  output  2  head entry error tag {parity, stop}; present only with UART_RX_FIFO_ERR_TAG_EN
- o_count  output  $clog2(Depth)+1  current occupancy, 0..Depth
- o_empty  output  1  occupancy == 0
- o_full  output  1  occupancy == Depth
- o_almost_full  output  1  occupancy >= AlmostFull
- o_overflow  output  1  sticky: a write was dropped
- i_clear_ovf  input  1  clears o_overflow
- i_flush  input  1  synchronous flush; empties the FIFO

Behaviour:
- Reset (async, i_rst=1):
  - Pointers and count are 0; o_overflow=0.
  - o_empty=1, o_rd_valid=0, o_full=0, o_almost_full=0.
  - o_rd_data and o_rd_err read the entry-0 storage; their value is don't-care while o_rd_valid=0. Storage is not cleared.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(Depth)+1 bits wide; the extra MSB distinguishes full from empty.
  - Both wrap modulo 2*Depth.
  - o_count = wr_ptr - rd_ptr, registered alongside the pointers.
- Write:
  - Accepted when i_wr_en=1 and (not full, or a read is accepted in the same cycle).
  - The entry is stored at wr_ptr[low bits]; wr_ptr increments.
- Read:
  - Transfer occurs when o_rd_valid && i_rd_ready; rd_ptr increments.
  - o_rd_valid = !o_empty.
  - o_rd_data = mem[rd_ptr] is a combinational read of registered storage, so a written character is visible the cycle after i_wr_en (1-cycle write-to-valid latency).
- Simultaneous write and read:
  - Both happen and the count is unchanged.
  - When full, the write is accepted because the read frees a slot.
  - When empty, the write is stored and o_rd_valid rises next cycle; there is no bypass, and the read does nothing because o_rd_valid=0.
- Overflow:
  - Condition: i_wr_en=1 while full and no accepted read.
  - The character is dropped; the pointers are unchanged; o_overflow sets next cycle and stays high.
  - i_clear_ovf=1 clears it next cycle. If overflow and clear coincide, set wins.
- Read when empty: i_rd_ready is ignored; no pointer change.
- Flush:
  - i_flush=1 sets rd_ptr <= wr_ptr after any same-cycle write is accounted, leaving count=0.
  - Flush overrides reads; o_overflow is unaffected.
- Flag timing: all flags are registered or derived from registered pointers; there are no combinational paths from i_wr_en to any output.
- Reset mid-operation: all pointers and flags return to reset values immediately; in-flight data is lost.

Optional Feature:
- Macro: UART_RX_FIFO_ERR_TAG_EN.
- Defined:
  - Each entry stores {i_parity_error, i_stop_bit_error} alongside the data (width DataLength+2).
  - o_rd_err presents the head entry's tag with the same timing as o_rd_data.
- Undefined:
  - Entries are DataLength wide; o_rd_err and both error inputs are absent from the port list.

Decomposition:
- Package uart_pkg holds:
  - typedef rx_err_t, a packed struct {parity, stop};
  - typedef rx_entry_t, a packed struct {data, err} under the macro;
  - helper function ptr_w(Depth) = $clog2(Depth)+1.
- Sub-module uart_fifo_mem:
  - Depth x width register array, one write port, one asynchronous read port, no reset.
  - Reusable for a future TX FIFO.

Test Plan:
- Single write of 8'hA5, i_rd_ready=0 -> next cycle o_rd_valid=1, o_rd_data=8'hA5, o_count=1, o_empty=0; assert ready -> next cycle o_empty=1, o_count=0.
- 16 writes 8'h00..8'h0F (Depth=16) -> o_almost_full rises after the 12th, o_full after the 16th; drain reads 8'h00..8'h0F in order.
- Full, write 8'hFF with no read -> dropped, o_overflow=1, count stays 16; i_clear_ovf -> o_overflow=0, head still 8'h00.
- Full, write 8'h77 with an accepted read in the same cycle -> count stays 16, no overflow, 8'h77 read last.
- Write with i_parity_error=1 (macro on) -> o_rd_err=2'b10 at head; with macro off the module compiles without error ports.
- 5 entries, then i_flush -> o_count=0, o_rd_valid=0; assert i_rst mid-burst -> all flags at reset values asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path.
// rx_entry_t exists only with UART_RX_FIFO_ERR_TAG_EN.
package uart_pkg;

  localparam int RX_DATA_W = 8;

  typedef struct packed {
    logic parity;
    logic stop;
  } rx_err_t;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  typedef struct packed {
    logic [RX_DATA_W-1:0] data;
    rx_err_t              err;
  } rx_entry_t;
`endif

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - Depth x Width register array, one write port, one async read port.
module uart_fifo_mem #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(Depth)-1:0] i_wr_addr,
  input  logic [Width-1:0]         i_wr_data,
  input  logic [$clog2(Depth)-1:0] i_rd_addr,
  output logic [Width-1:0]         o_rd_data
);

  logic [Width-1:0] mem_q [Depth];

  // No reset: contents are only meaningful behind the owner's valid flag.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive buffer behind the UART receiver.
// Optional per-entry {parity, stop} tag: UART_RX_FIFO_ERR_TAG_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DataLength = 8,
  parameter int Depth      = 16,
  parameter int AlmostFull = 12
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_en,
  input  logic [DataLength-1:0]        i_wr_data,
`ifdef UART_RX_FIFO_ERR_TAG_EN
  input  logic                         i_parity_error,
  input  logic                         i_stop_bit_error,
  output logic [1:0]                   o_rd_err,
`endif
  output logic                         o_rd_valid,
  input  logic                         i_rd_ready,
  output logic [DataLength-1:0]        o_rd_data,
  output logic [$clog2(Depth):0]       o_count,
  output logic                         o_empty,
  output logic                         o_full,
  output logic                         o_almost_full,
  output logic                         o_overflow,
  input  logic                         i_clear_ovf,
  input  logic                         i_flush
);

  localparam int PtrW  = ptr_w(Depth);
  localparam int AddrW = PtrW - 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int EntryW = DataLength + $bits(rx_err_t);
`else
  localparam int EntryW = DataLength;
`endif
  localparam logic [PtrW-1:0] DepthC = PtrW'(Depth);
  localparam logic [PtrW-1:0] AfC    = PtrW'(AlmostFull);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rd_fire, wr_ok;
  logic [EntryW-1:0] wr_entry, rd_entry;

  always_comb begin
    rd_fire  = (count_q != '0) && i_rd_ready;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    wr_ok    = i_wr_en && ((count_q != DepthC) || rd_fire);
    wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, wr_ok};
    rd_ptr_d = i_flush ? wr_ptr_d : rd_ptr_q + {{(PtrW-1){1'b0}}, rd_fire};
    count_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = ovf_q;
    if (i_clear_ovf) ovf_d = 1'b0;
    if (i_wr_en && !wr_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef UART_RX_FIFO_ERR_TAG_EN
  rx_err_t wr_err, rd_err;
  assign wr_err.parity = i_parity_error;
  assign wr_err.stop   = i_stop_bit_error;
  assign wr_entry      = {i_wr_data, wr_err};
  assign {o_rd_data, rd_err} = rd_entry;
  assign o_rd_err      = rd_err;
`else
  assign wr_entry  = i_wr_data;
  assign o_rd_data = rd_entry;
`endif

  uart_fifo_mem #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_ok),
    .i_wr_addr (wr_ptr_q[AddrW-1:0]),
    .i_wr_data (wr_entry),
    .i_rd_addr (rd_ptr_q[AddrW-1:0]),
    .o_rd_data (rd_entry)
  );

  assign o_count       = count_q;
  assign o_empty       = (count_q == '0);
  assign o_rd_valid    = (count_q != '0);
  assign o_full        = (count_q == DepthC);
  assign o_almost_full = (count_q >= AfC);
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - table-driven self-checking bench for uart_rx_fifo.
// Error-tag sequence runs only with UART_RX_FIFO_ERR_TAG_EN.
module tb_uart_rx_fifo;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rdy;
    logic       fl;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       cd;
    logic [4:0] ec;
    logic       ef;
    logic       eaf;
    logic       eo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_ready;
  logic       clear_ovf;
  logic       flush;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full, almost_full, overflow;
`ifdef UART_RX_FIFO_ERR_TAG_EN
  logic       parity_error, stop_bit_error;
  logic [1:0] rd_err;
`endif

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DataLength(8), .Depth(16), .AlmostFull(12)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_wr_en          (wr_en),
    .i_wr_data        (wr_data),
`ifdef UART_RX_FIFO_ERR_TAG_EN
    .i_parity_error   (parity_error),
    .i_stop_bit_error (stop_bit_error),
    .o_rd_err         (rd_err),
`endif
    .o_rd_valid       (rd_valid),
    .i_rd_ready       (rd_ready),
    .o_rd_data        (rd_data),
    .o_count          (count),
    .o_empty          (empty),
    .o_full           (full),
    .o_almost_full    (almost_full),
    .o_overflow       (overflow),
    .i_clear_ovf      (clear_ovf),
    .i_flush          (flush)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] wd, input logic rdy,
                              input logic fl, input logic clr, input logic [7:0] ed,
                              input logic cd, input int ec, input logic eo);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rdy = rdy; v.fl = fl; v.clr = clr;
    v.ec  = 5'(ec);
    v.ev  = (ec != 0);
    v.ed  = ed;
    v.cd  = cd;
    v.ef  = (ec == 16);
    v.eaf = (ec >= 12);
    v.eo  = eo;
    return v;
  endfunction

  task automatic idle_inputs();
    wr_en = 0; wr_data = '0; rd_ready = 0; clear_ovf = 0; flush = 0;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    parity_error = 0; stop_bit_error = 0;
`endif
  endtask

  task automatic check_reset_flags(input int idx);
    chk("rst_count", idx, 32'(count), 0);
    chk("rst_empty", idx, 32'(empty), 1);
    chk("rst_valid", idx, 32'(rd_valid), 0);
    chk("rst_full", idx, 32'(full), 0);
    chk("rst_afull", idx, 32'(almost_full), 0);
    chk("rst_ovf", idx, 32'(overflow), 0);
  endtask

  initial begin
    // wr wd rdy fl clr | head cd count ovf
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 8'hA5, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 8'(i), 0, 0, 0, 8'h00, 1, i + 1, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 8'h00, 1, 16, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 1, 16, 0));
    tbl.push_back(mk(1, 8'hFE, 0, 0, 1, 8'h00, 1, 16, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h00, 1, 16, 0));
    tbl.push_back(mk(1, 8'h77, 1, 0, 0, 8'h01, 1, 16, 0));
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, (k < 14) ? 8'(k + 2) : 8'h77, k < 15, 15 - k, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 8'(8'h50 + i), 0, 0, 0, 8'h50, 1, i + 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 1, 0, 0, 8'h3C, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));

    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_flags(0);
    rst = 0;

    foreach (tbl[i]) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].wd; rd_ready = tbl[i].rdy;
      flush = tbl[i].fl; clear_ovf = tbl[i].clr;
      @(posedge clk);
      #1;
      chk("count", i, 32'(count), 32'(tbl[i].ec));
      chk("valid", i, 32'(rd_valid), 32'(tbl[i].ev));
      chk("empty", i, 32'(empty), 32'(!tbl[i].ev));
      chk("full", i, 32'(full), 32'(tbl[i].ef));
      chk("afull", i, 32'(almost_full), 32'(tbl[i].eaf));
      chk("ovf", i, 32'(overflow), 32'(tbl[i].eo));
      if (tbl[i].cd) chk("data", i, 32'(rd_data), 32'(tbl[i].ed));
    end
    idle_inputs();

    // Async reset in the middle of a write burst, checked before any clock edge.
    wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h90 + i);
      @(posedge clk);
      #1;
    end
    chk("burst_count", 1, 32'(count), 3);
    #2 rst = 1;
    #1;
    check_reset_flags(1);
    idle_inputs();
    @(posedge clk);
    #1;
    check_reset_flags(2);
    rst = 0;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    wr_en = 1; wr_data = 8'hC3; parity_error = 1; stop_bit_error = 0;
    @(posedge clk);
    #1;
    wr_data = 8'h3C; parity_error = 0; stop_bit_error = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("tag_data0", 0, 32'(rd_data), 32'h00C3);
    chk("tag_err0", 0, 32'(rd_err), 32'h2);
    rd_ready = 1;
    @(posedge clk);
    #1;
    rd_ready = 0;
    chk("tag_data1", 1, 32'(rd_data), 32'h003C);
    chk("tag_err1", 1, 32'(rd_err), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
